// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch queue.
// It issues one instruction-memory request per cycle while there is room.
// It buffers each {instr, pc+step} pair and hands them to decode over valid/ready.
// A redirect flushes the queue and the in-flight fetch. A HALT_WORD stops fetching.
module fetch_prefetch_unit #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PC_STEP   = 4,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc_plus4,
  output logic              halted,
  output logic              misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fetch_addr;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW:0]       occupancy;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pcp_q   [DEPTH];

  // The issue rule counts queued entries plus the outstanding fetch, so every response has a free slot.
  // A response that arrives after HALT_WORD was enqueued is dropped.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req  = ~reset & ~halted & (occupancy < {1'b0, DEPTH_C});
    imem_addr = pc;
    push      = ~reset & ~redirect & inflight & ~halted;
    out_valid = (count != '0);
    pop       = out_valid & out_ready & ~redirect;
    out_instr    = out_valid ? instr_q[head] : '0;
    out_pc_plus4 = out_valid ? pcp_q[head]   : '0;
  end

  // Updates the PC, the in-flight flag, the queue pointers, the count and the sticky flags.
  // Redirect overrides everything else in its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      fetch_addr   <= '0;
      inflight     <= 1'b0;
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      pc         <= {redirect_target[ADDR_W-1:2], 2'b00};
      fetch_addr <= pc;
      inflight   <= 1'b0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      halted     <= 1'b0;
      if (redirect_target[1:0] != 2'b00)
        misalign_err <= 1'b1;
    end else begin
      if (imem_req)
        pc <= pc + STEP_C;
      fetch_addr <= pc;
      inflight   <= imem_req;
      if (push)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && (imem_rdata == HALT_WORD))
        halted <= 1'b1;
    end
  end

  // Writes the returning instruction and its successor address into the queue at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail] <= imem_rdata;
      pcp_q[tail]   <= fetch_addr + STEP_C;
    end
  end

  // The issue rule reserves a slot for every response, so a push into a full queue without a pop is a design error.
  assert property (@(posedge clk) disable iff (reset) !(push && !pop && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard testbench for fetch_prefetch_unit.
// It contains a behavioural instruction memory and a second instance that checks PC wrap-around.
module tb_fetch_prefetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        halted;
  logic        misalign_err;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] out_instr2;
  logic [31:0] out_pc_plus4_2;
  logic        halted2;
  logic        misalign_err2;

  logic        halt_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  entry_t      expq[$];
  logic [31:0] addrq2[$];

  fetch_prefetch_unit dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .halted(halted), .misalign_err(misalign_err)
  );

  fetch_prefetch_unit #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
    .clk(clk), .reset(reset), .redirect(1'b0), .redirect_target(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_pc_plus4(out_pc_plus4_2), .halted(halted2), .misalign_err(misalign_err2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (halt_en && a == 32'h10) return 32'hFFFFFFFF;
    return (a >> 2) + 32'd1;
  endfunction

  function automatic logic [31:0] memWord2(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  // Synchronous-read memories: the data comes back one cycle after the address.
  always @(posedge clk) begin
    imem_rdata  <= memWord(imem_addr);
    imem_rdata2 <= memWord2(imem_addr2);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdr, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    redirect        = rdr;
    redirect_target = tgt;
    out_ready       = rdy;
  endtask

  task automatic pushRange(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      expq.push_back({memWord(a), a + 32'd4});
    end
  endtask

  // Every accepted handshake on the main instance is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && !redirect && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_delivery", {32'h0, out_pc_plus4}, 64'h0);
      end else begin
        entry_t e;
        e = expq.pop_front();
        checkOutput("instr", {32'h0, out_instr}, {32'h0, e.instr});
        checkOutput("pc_plus4", {32'h0, out_pc_plus4}, {32'h0, e.pcp});
      end
    end
  end

  // Fetch addresses of the wrap-around instance are compared against the expected sequence.
  always @(negedge clk) begin
    if (!reset && imem_req2 && addrq2.size() != 0)
      checkOutput("wrap_fetch_addr", {32'h0, imem_addr2}, {32'h0, addrq2.pop_front()});
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_target = '0; out_ready = 1'b0; out_ready2 = 1'b0;
    for (int i = 0; i < 16; i++) addrq2.push_back(32'hFFFFFFF8 + 32'(4 * i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("rst_imem_req", {63'h0, imem_req}, 64'h0);
    checkOutput("rst_out_instr", {32'h0, out_instr}, 64'h0);
    checkOutput("rst_pc_plus4", {32'h0, out_pc_plus4}, 64'h0);
    checkOutput("rst_halted", {63'h0, halted}, 64'h0);
    checkOutput("rst_misalign", {63'h0, misalign_err}, 64'h0);

    pushRange(32'h0, 40);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("first_req", {63'h0, imem_req}, 64'h1);
        checkOutput("first_addr", {32'h0, imem_addr}, 64'h0);
      end
      checkOutput("fill_valid", {63'h0, out_valid}, {63'h0, (c >= 2)});
    end

    // Stall decode until the queue fills and fetching stops.
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("full_req_off", {63'h0, imem_req}, 64'h0);
    checkOutput("full_valid", {63'h0, out_valid}, 64'h1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);

    // Redirect to 0x40 with a full queue.
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0);
    expq.delete();
    pushRange(32'h40, 8);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("redir_t1_valid", {63'h0, out_valid}, 64'h0);
    checkOutput("redir_t1_req", {63'h0, imem_req}, 64'h1);
    checkOutput("redir_t1_addr", {32'h0, imem_addr}, 64'h40);
    @(negedge clk);
    checkOutput("redir_t2_valid", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    checkOutput("redir_t3_valid", {63'h0, out_valid}, 64'h1);
    checkOutput("redir_t3_pcp", {32'h0, out_pc_plus4}, 64'h44);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

    // Misaligned redirect is aligned down and sets the sticky flag.
    applyStimulus(1'b1, 32'h42, 1'b1);
    expq.delete();
    pushRange(32'h40, 12);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("misalign_set", {63'h0, misalign_err}, 64'h1);
    checkOutput("misalign_addr", {32'h0, imem_addr}, 64'h40);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);

    // HALT_WORD at 0x10 stops fetching after it drains.
    halt_en = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b1);
    expq.delete();
    pushRange(32'h0, 5);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("misalign_sticky", {63'h0, misalign_err}, 64'h1);
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("halted_set", {63'h0, halted}, 64'h1);
    checkOutput("halted_no_req", {63'h0, imem_req}, 64'h0);
    checkOutput("halted_drained", {63'h0, out_valid}, 64'h0);
    checkOutput("halt_all_delivered", 64'(expq.size()), 64'h0);

    // A redirect clears halt and restarts fetching.
    halt_en = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0);
    expq.delete();
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("halt_cleared", {63'h0, halted}, 64'h0);
    checkOutput("restart_req", {63'h0, imem_req}, 64'h1);
    checkOutput("restart_addr", {32'h0, imem_addr}, 64'h0);

    // The wrap-around instance has been stalled since reset and holds four entries.
    checkOutput("wrap_full_no_req", {63'h0, imem_req2}, 64'h0);
    checkOutput("wrap_valid", {63'h0, out_valid2}, 64'h1);
    @(posedge clk); #1;
    out_ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a2;
      a2 = 32'hFFFFFFF8 + 32'(4 * k);
      @(negedge clk);
      checkOutput("wrap_out_valid", {63'h0, out_valid2}, 64'h1);
      checkOutput("wrap_instr", {32'h0, out_instr2}, {32'h0, memWord2(a2)});
      checkOutput("wrap_pc_plus4", {32'h0, out_pc_plus4_2}, {32'h0, a2 + 32'd4});
    end
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
